mem_bus_arbiter: RTL

- Shares one Wishbone-classic memory bus between the instruction-fetch port and the data-access (load/store) port of the pipeline.
- Sequences single-beat transactions: one outstanding at a time, data port has priority.
- Raises per-port stall requests to the pipeline controller until each port's access has completed.
- Holds each port's read result stable while the pipeline is stalled for other reasons.

---
 rtl/mem_bus_arbiter_pkg.sv | 9 +
 rtl/mem_bus_arbiter_port_tracker.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding, timeout default and Wishbone width constants
package mem_bus_arbiter_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;
  localparam int TIMEOUT_DEF = 255;
  localparam logic [WB_SW-1:0] SEL_FULL = 4'hF;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_M = 2'd1, BUSY_IF = 2'd2} arb_state_e;
endpackage

// File: rtl/mem_bus_arbiter_port_tracker.sv
// mem_bus_arbiter_port_tracker: per-port done flag, result hold register and stall request (ce/stall/flush/set/load/ldata in; done/data/stallreq out)
module mem_bus_arbiter_port_tracker
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             stall,
  input  logic             flush,
  input  logic             set,
  input  logic             load,
  input  logic [WB_DW-1:0] ldata,
  output logic             done,
  output logic [WB_DW-1:0] data,
  output logic             stallreq
);
  assign stallreq = ce & ~done & ~rst;
  always_ff @(posedge clk)
    if (rst) begin
      done <= 1'b0;
      data <= '0;
    end else begin
      done <= ~flush & (set | (done & stall));
      if (load) data <= ldata;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone-classic bus between fetch (if_*) and load/store (m_*) ports, data port first, with stall requests, flush discard and timeout (bus_* master side)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC   = TIMEOUT_DEF,
  parameter bit RESET_WE_GATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ce_i,
  input  logic [WB_AW-1:0] if_addr_i,
  output logic [WB_DW-1:0] if_data_o,
  input  logic             if_stall_i,
  output logic             stallreq_if_o,
  input  logic             m_ce_i,
  input  logic             m_we_i,
  input  logic [WB_SW-1:0] m_sel_i,
  input  logic [WB_AW-1:0] m_addr_i,
  input  logic [WB_DW-1:0] m_wdata_i,
  output logic [WB_DW-1:0] m_rdata_o,
  input  logic             m_stall_i,
  output logic             stallreq_mem_o,
  input  logic             flush_i,
  output logic             bus_cyc_o,
  output logic             bus_stb_o,
  output logic             bus_we_o,
  output logic [WB_SW-1:0] bus_sel_o,
  output logic [WB_AW-1:0] bus_adr_o,
  output logic [WB_DW-1:0] bus_dat_o,
  input  logic [WB_DW-1:0] bus_dat_i,
  input  logic             bus_ack_i,
  output logic             bus_timeout_o
);
  arb_state_e state, state_n;
  logic [15:0] cnt;
  logic discard, we_q, done_if, done_m;
  logic start_m, start_if, ack, tmo, fin, fin_m, fin_if;
  logic [WB_DW-1:0] rdata;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = start_m ? BUSY_M : start_if ? BUSY_IF : fin ? IDLE : state;
  always_comb begin
    start_m = state == IDLE && m_ce_i && !done_m && !flush_i;
    start_if = state == IDLE && !start_m && if_ce_i && !done_if && !flush_i;
    ack = state != IDLE && bus_ack_i;
    tmo = state != IDLE && !bus_ack_i && cnt == 16'(TIMEOUT_CYC - 1);
    fin = ack || tmo;
    fin_m = fin && state == BUSY_M && !discard && !flush_i;
    fin_if = fin && state == BUSY_IF && !discard && !flush_i;
    rdata = tmo ? '0 : bus_dat_i;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus_cyc_o <= 1'b0;
      bus_stb_o <= 1'b0;
      we_q <= 1'b0;
      bus_sel_o <= '0;
      bus_adr_o <= '0;
      bus_dat_o <= '0;
      bus_timeout_o <= 1'b0;
      discard <= 1'b0;
      cnt <= '0;
    end else begin
      bus_timeout_o <= tmo;
      cnt <= state == IDLE || fin ? '0 : cnt + 16'd1;
      discard <= state != IDLE && !fin && (discard || flush_i);
      if (start_m || start_if) begin
        bus_cyc_o <= 1'b1;
        bus_stb_o <= 1'b1;
        we_q <= start_m && m_we_i;
        bus_sel_o <= start_m ? m_sel_i : SEL_FULL;
        bus_adr_o <= start_m ? m_addr_i : if_addr_i;
        if (start_m) bus_dat_o <= m_wdata_i;
      end else if (fin) begin
        bus_cyc_o <= 1'b0;
        bus_stb_o <= 1'b0;
      end
    end
  assign bus_we_o = we_q & ~(RESET_WE_GATE & (state == BUSY_IF));
  mem_bus_arbiter_port_tracker u_trk_m (
    .clk(clk), .rst(rst), .ce(m_ce_i), .stall(m_stall_i), .flush(flush_i),
    .set(fin_m), .load(fin_m && !we_q), .ldata(rdata),
    .done(done_m), .data(m_rdata_o), .stallreq(stallreq_mem_o)
  );
  mem_bus_arbiter_port_tracker u_trk_if (
    .clk(clk), .rst(rst), .ce(if_ce_i), .stall(if_stall_i), .flush(flush_i),
    .set(fin_if), .load(fin_if), .ldata(rdata),
    .done(done_if), .data(if_data_o), .stallreq(stallreq_if_o)
  );
endmodule
